// File: rtl/mem_port_arbiter_if.sv
// CPU-side (fetch + data) and memory-side handshake bundle for mem_port_arbiter.
// The arbiter uses the slave view; the CPU/memory environment uses the master view.
interface mem_port_arbiter_if;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;

    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ready,
        input  Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
        input  mem_req_ready, mem_rdata, mem_rdata_valid,
        output Inst_Req_Ready, Instruction, Inst_Valid,
        output Mem_Req_Ready, Read_data, Read_data_Valid,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );

    modport master (
        output PC, Inst_Req_Valid, Inst_Ready,
        output Address, MemRead, MemWrite, Write_data, Write_strb, Read_data_Ready,
        output mem_req_ready, mem_rdata, mem_rdata_valid,
        input  Inst_Req_Ready, Instruction, Inst_Valid,
        input  Mem_Req_Ready, Read_data, Read_data_Valid,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU fetch and data channels,
// one outstanding transaction at a time, with response timeout and debug counters.
module mem_port_arbiter #(
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy,
    output logic                err_timeout,
    output logic [31:0]         inst_cnt,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         wr_cnt
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
    typedef enum logic {OwnInst, OwnData} owner_e;

    localparam bit          TimeoutEn   = (TIMEOUT != 0);
    localparam logic [31:0] TimeoutLast = TimeoutEn ? 32'(TIMEOUT - 1) : 32'd0;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wait_q, wait_d;
    logic        err_q, err_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    logic data_req;
    logic data_wins;
    logic grant_data;
    logic grant_inst;
    logic resp_taken;

    // Round-robin only matters when both channels compete; then the loser of last time wins.
    assign data_req   = bus.MemRead | bus.MemWrite;
    assign data_wins  = data_req &&
                        (!bus.Inst_Req_Valid || (ARB_MODE == 0) || (last_grant_q == OwnInst));
    assign grant_data = (state_q == StIdle) && data_wins;
    assign grant_inst = (state_q == StIdle) && bus.Inst_Req_Valid && !data_wins;
    assign resp_taken = (owner_q == OwnInst) ? bus.Inst_Ready : bus.Read_data_Ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        inst_d       = inst_q;
        rdata_d      = rdata_q;
        wait_d       = wait_q;
        err_d        = err_q;
        inst_cnt_d   = inst_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;

        case (state_q)
            StIdle: begin
                if (grant_data) begin
                    addr_d       = bus.Address;
                    wen_d        = bus.MemWrite; // read+write together is a plain write
                    wdata_d      = bus.Write_data;
                    wstrb_d      = bus.Write_strb;
                    owner_d      = OwnData;
                    last_grant_d = OwnData;
                    state_d      = StReq;
                end else if (grant_inst) begin
                    addr_d       = bus.PC;
                    wen_d        = 1'b0;
                    wdata_d      = 32'h0;
                    wstrb_d      = 4'h0;
                    owner_d      = OwnInst;
                    last_grant_d = OwnInst;
                    state_d      = StReq;
                end
            end
            StReq: begin
                if (bus.mem_req_ready) begin
                    if (wen_q) begin
                        wr_cnt_d = wr_cnt_q + 32'd1;
                        state_d  = StIdle;
                    end else begin
                        wait_d  = 32'd0;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                wait_d = wait_q + 32'd1;
                if (bus.mem_rdata_valid) begin
                    if (owner_q == OwnInst) inst_d = bus.mem_rdata;
                    else                    rdata_d = bus.mem_rdata;
                    state_d = StResp;
                end else if (TimeoutEn && (wait_q == TimeoutLast)) begin
                    if (owner_q == OwnInst) inst_d = 32'h0;
                    else                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_taken) begin
                    if (owner_q == OwnInst) inst_cnt_d = inst_cnt_q + 32'd1;
                    else                    rd_cnt_d   = rd_cnt_q + 32'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            owner_q      <= OwnData;
            last_grant_q <= OwnData;
            addr_q       <= 32'h0;
            wen_q        <= 1'b0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            inst_q       <= 32'h0;
            rdata_q      <= 32'h0;
            wait_q       <= 32'h0;
            err_q        <= 1'b0;
            inst_cnt_q   <= 32'h0;
            rd_cnt_q     <= 32'h0;
            wr_cnt_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            inst_q       <= inst_d;
            rdata_q      <= rdata_d;
            wait_q       <= wait_d;
            err_q        <= err_d;
            inst_cnt_q   <= inst_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign bus.Inst_Req_Ready  = grant_inst;
    assign bus.Mem_Req_Ready   = grant_data;
    assign bus.Instruction     = inst_q;
    assign bus.Inst_Valid      = (state_q == StResp) && (owner_q == OwnInst);
    assign bus.Read_data       = rdata_q;
    assign bus.Read_data_Valid = (state_q == StResp) && (owner_q == OwnData);
    assign bus.mem_req_valid   = (state_q == StReq);
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wen         = wen_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_wstrb       = wstrb_q;

    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;
    assign inst_cnt    = inst_cnt_q;
    assign rd_cnt      = rd_cnt_q;
    assign wr_cnt      = wr_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut0 uses fixed priority, dut1 round-robin,
// both with an 8-cycle response timeout.
module tb_mem_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if bi0 ();
    mem_port_arbiter_if bi1 ();

    logic        busy0, err0, busy1, err1;
    logic [31:0] icnt0, rcnt0, wcnt0, icnt1, rcnt1, wcnt1;

    mem_port_arbiter #(.ARB_MODE(0), .TIMEOUT(8)) u_dut0 (
        .clock(clock), .reset(reset), .bus(bi0), .busy(busy0), .err_timeout(err0),
        .inst_cnt(icnt0), .rd_cnt(rcnt0), .wr_cnt(wcnt0)
    );

    mem_port_arbiter #(.ARB_MODE(1), .TIMEOUT(8)) u_dut1 (
        .clock(clock), .reset(reset), .bus(bi1), .busy(busy1), .err_timeout(err1),
        .inst_cnt(icnt1), .rd_cnt(rcnt1), .wr_cnt(wcnt1)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bi0.PC = 0; bi0.Inst_Req_Valid = 0; bi0.Inst_Ready = 0; bi0.Address = 0;
        bi0.MemRead = 0; bi0.MemWrite = 0; bi0.Write_data = 0; bi0.Write_strb = 0;
        bi0.Read_data_Ready = 0; bi0.mem_req_ready = 0; bi0.mem_rdata = 0;
        bi0.mem_rdata_valid = 0;
        bi1.PC = 0; bi1.Inst_Req_Valid = 0; bi1.Inst_Ready = 0; bi1.Address = 0;
        bi1.MemRead = 0; bi1.MemWrite = 0; bi1.Write_data = 0; bi1.Write_strb = 0;
        bi1.Read_data_Ready = 0; bi1.mem_req_ready = 0; bi1.mem_rdata = 0;
        bi1.mem_rdata_valid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        step();
        step();
        checks++;
        if ({busy0, err0, icnt0, rcnt0, wcnt0} !== 98'h0) begin
            failures++;
            $display("FAIL reset_status: got busy=%b err=%b cnt=%h/%h/%h want all 0",
                     busy0, err0, icnt0, rcnt0, wcnt0);
        end
        checks++;
        if ({bi0.Inst_Req_Ready, bi0.Mem_Req_Ready, bi0.Inst_Valid, bi0.Read_data_Valid,
             bi0.mem_req_valid, bi0.Instruction, bi0.Read_data, bi0.mem_addr,
             bi0.mem_wen, bi0.mem_wdata, bi0.mem_wstrb} !== 138'h0) begin
            failures++;
            $display("FAIL reset_outputs: got vld=%b%b%b%b%b inst=%h rd=%h addr=%h want 0",
                     bi0.Inst_Req_Ready, bi0.Mem_Req_Ready, bi0.Inst_Valid,
                     bi0.Read_data_Valid, bi0.mem_req_valid, bi0.Instruction,
                     bi0.Read_data, bi0.mem_addr);
        end
        reset = 1;
    endtask

    task automatic test_fetch();
        do_reset();
        bi0.PC = 32'h8000_0000;
        bi0.Inst_Req_Valid = 1;
        #1;
        checks++;
        if ({bi0.Inst_Req_Ready, bi0.Mem_Req_Ready} !== 2'b10) begin
            failures++;
            $display("FAIL fetch_ready: got %b want 10", {bi0.Inst_Req_Ready, bi0.Mem_Req_Ready});
        end
        step();
        bi0.Inst_Req_Valid = 0;
        checks++;
        if ({bi0.mem_req_valid, bi0.mem_addr, bi0.mem_wen} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            failures++;
            $display("FAIL fetch_req: got v=%b addr=%h wen=%b want 1 80000000 0",
                     bi0.mem_req_valid, bi0.mem_addr, bi0.mem_wen);
        end
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        step();
        bi0.mem_rdata = 32'h0000_0413;
        bi0.mem_rdata_valid = 1;
        step();
        bi0.mem_rdata_valid = 0;
        bi0.mem_rdata = 32'hFFFF_FFFF;
        step();
        checks++;
        if ({bi0.Inst_Valid, bi0.Instruction, bi0.Read_data_Valid} !== {1'b1, 32'h413, 1'b0}) begin
            failures++;
            $display("FAIL fetch_resp: got v=%b inst=%h rdv=%b want 1 00000413 0",
                     bi0.Inst_Valid, bi0.Instruction, bi0.Read_data_Valid);
        end
        bi0.Inst_Ready = 1;
        step();
        bi0.Inst_Ready = 0;
        checks++;
        if ({busy0, bi0.Inst_Valid, icnt0} !== {1'b0, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL fetch_done: got busy=%b v=%b inst_cnt=%0d want 0 0 1",
                     busy0, bi0.Inst_Valid, icnt0);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bi0.PC = 32'h100;
        bi0.Inst_Req_Valid = 1;
        bi0.Address = 32'h200;
        bi0.MemRead = 1;
        #1;
        checks++;
        if ({bi0.Inst_Req_Ready, bi0.Mem_Req_Ready} !== 2'b01) begin
            failures++;
            $display("FAIL prio_grant: got %b want 01", {bi0.Inst_Req_Ready, bi0.Mem_Req_Ready});
        end
        step();
        bi0.MemRead = 0;
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        bi0.mem_rdata = 32'h1111_2222;
        bi0.mem_rdata_valid = 1;
        step();
        bi0.mem_rdata_valid = 0;
        bi0.Read_data_Ready = 1;
        checks++;
        if ({bi0.Read_data_Valid, bi0.Read_data, bi0.Inst_Req_Ready} !==
            {1'b1, 32'h1111_2222, 1'b0}) begin
            failures++;
            $display("FAIL prio_load: got v=%b data=%h irdy=%b want 1 11112222 0",
                     bi0.Read_data_Valid, bi0.Read_data, bi0.Inst_Req_Ready);
        end
        step();
        bi0.Read_data_Ready = 0;
        step();
        bi0.Inst_Req_Valid = 0;
        checks++;
        if ({bi0.mem_req_valid, bi0.mem_addr} !== {1'b1, 32'h100}) begin
            failures++;
            $display("FAIL prio_fetch_req: got v=%b addr=%h want 1 00000100",
                     bi0.mem_req_valid, bi0.mem_addr);
        end
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        bi0.mem_rdata = 32'h3333_4444;
        bi0.mem_rdata_valid = 1;
        step();
        bi0.mem_rdata_valid = 0;
        bi0.Inst_Ready = 1;
        step();
        bi0.Inst_Ready = 0;
        checks++;
        if ({bi0.Instruction, rcnt0, icnt0} !== {32'h3333_4444, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL prio_counts: got inst=%h rd_cnt=%0d inst_cnt=%0d want 33334444 1 1",
                     bi0.Instruction, rcnt0, icnt0);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_grant;
        do_reset();
        bi1.PC = 32'hA0;
        bi1.Inst_Req_Valid = 1;
        bi1.Address = 32'hD0;
        bi1.MemRead = 1;
        bi1.Inst_Ready = 1;
        bi1.Read_data_Ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_grant = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({bi1.Inst_Req_Ready, bi1.Mem_Req_Ready} !== exp_grant) begin
                failures++;
                $display("FAIL rr_grant%0d: got %b want %b", i,
                         {bi1.Inst_Req_Ready, bi1.Mem_Req_Ready}, exp_grant);
            end
            step();
            bi1.mem_req_ready = 1;
            step();
            bi1.mem_req_ready = 0;
            bi1.mem_rdata = 32'(i);
            bi1.mem_rdata_valid = 1;
            step();
            bi1.mem_rdata_valid = 0;
            step();
        end
        checks++;
        if ({icnt1, rcnt1, bi1.Instruction, bi1.Read_data} !== {32'd2, 32'd2, 32'd2, 32'd3}) begin
            failures++;
            $display("FAIL rr_counts: got ic=%0d rc=%0d inst=%h rd=%h want 2 2 2 3",
                     icnt1, rcnt1, bi1.Instruction, bi1.Read_data);
        end
        clear_inputs();
    endtask

    task automatic test_store();
        do_reset();
        bi0.Address = 32'h8000_1000;
        bi0.Write_data = 32'hAABB_CCDD;
        bi0.Write_strb = 4'b0011;
        bi0.MemWrite = 1;
        step();
        bi0.MemWrite = 0;
        bi0.Address = 32'h0BAD_0BAD;
        bi0.Write_data = 32'h1234_5678;
        bi0.Write_strb = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bi0.mem_req_valid, bi0.mem_addr, bi0.mem_wen, bi0.mem_wdata, bi0.mem_wstrb} !==
                {1'b1, 32'h8000_1000, 1'b1, 32'hAABB_CCDD, 4'b0011}) begin
                failures++;
                $display("FAIL store_hold%0d: got v=%b a=%h w=%b d=%h s=%b want 1 80001000 1 aabbccdd 0011",
                         k, bi0.mem_req_valid, bi0.mem_addr, bi0.mem_wen, bi0.mem_wdata,
                         bi0.mem_wstrb);
            end
            step();
        end
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        step();
        checks++;
        if ({busy0, bi0.Read_data_Valid, wcnt0, rcnt0} !== {1'b0, 1'b0, 32'd1, 32'd0}) begin
            failures++;
            $display("FAIL store_done: got busy=%b rdv=%b wr_cnt=%0d rd_cnt=%0d want 0 0 1 0",
                     busy0, bi0.Read_data_Valid, wcnt0, rcnt0);
        end
        // Read and write together: behaves as a write, zero strobe passes through.
        bi0.MemRead = 1;
        bi0.MemWrite = 1;
        bi0.Write_strb = 4'b0000;
        step();
        bi0.MemRead = 0;
        bi0.MemWrite = 0;
        checks++;
        if ({bi0.mem_wen, bi0.mem_wstrb} !== {1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL rw_both_req: got wen=%b strb=%b want 1 0000", bi0.mem_wen, bi0.mem_wstrb);
        end
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        step();
        checks++;
        if ({busy0, bi0.Read_data_Valid, wcnt0} !== {1'b0, 1'b0, 32'd2}) begin
            failures++;
            $display("FAIL rw_both_done: got busy=%b rdv=%b wr_cnt=%0d want 0 0 2",
                     busy0, bi0.Read_data_Valid, wcnt0);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        // Prime Read_data with a nonzero value so the timeout's zero capture is visible.
        bi0.MemRead = 1;
        bi0.Address = 32'h40;
        step();
        bi0.MemRead = 0;
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        bi0.mem_rdata = 32'hDEAD_BEEF;
        bi0.mem_rdata_valid = 1;
        step();
        bi0.mem_rdata_valid = 0;
        bi0.Read_data_Ready = 1;
        step();
        bi0.Read_data_Ready = 0;
        bi0.MemRead = 1;
        step();
        bi0.MemRead = 0;
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        repeat (7) step();
        checks++;
        if ({bi0.Read_data_Valid, err0, busy0, bi0.Read_data} !== {1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL timeout_wait: got rdv=%b err=%b busy=%b data=%h want 0 0 1 deadbeef",
                     bi0.Read_data_Valid, err0, busy0, bi0.Read_data);
        end
        step();
        checks++;
        if ({bi0.Read_data_Valid, err0, bi0.Read_data} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL timeout_resp: got rdv=%b err=%b data=%h want 1 1 00000000",
                     bi0.Read_data_Valid, err0, bi0.Read_data);
        end
        bi0.Read_data_Ready = 1;
        step();
        bi0.Read_data_Ready = 0;
        repeat (3) step();
        checks++;
        if ({err0, busy0, rcnt0} !== {1'b1, 1'b0, 32'd2}) begin
            failures++;
            $display("FAIL timeout_sticky: got err=%b busy=%b rd_cnt=%0d want 1 0 2",
                     err0, busy0, rcnt0);
        end
    endtask

    task automatic test_mid_reset();
        bi0.Address = 32'h123;
        bi0.MemRead = 1;
        step();
        bi0.MemRead = 0;
        bi0.mem_req_ready = 1;
        step();
        bi0.mem_req_ready = 0;
        reset = 0;
        step();
        reset = 1;
        bi0.mem_rdata = 32'h5555_AAAA;
        bi0.mem_rdata_valid = 1;
        step();
        bi0.mem_rdata_valid = 0;
        step();
        checks++;
        if ({busy0, err0, bi0.Read_data_Valid, bi0.mem_req_valid, bi0.Read_data, bi0.mem_addr,
             rcnt0} !== 100'h0) begin
            failures++;
            $display("FAIL mid_reset: got busy=%b err=%b rdv=%b mv=%b rd=%h addr=%h rc=%0d want 0",
                     busy0, err0, bi0.Read_data_Valid, bi0.mem_req_valid, bi0.Read_data,
                     bi0.mem_addr, rcnt0);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_round_robin();
        test_store();
        test_timeout();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
